// File: rtl/imm_insn_encoder.sv
// RV32I immediate packer: clears a template's immediate field and inserts an immediate in I/S/B/J/U
// layout, or expands LI into ADDI / LUI / LUI+ADDI. Single output register with valid/ready handshake.
module imm_insn_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_imm_src,
   input  logic [31:0] in_base,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_insn,
   output logic        out_err
);

   typedef enum logic [1:0] {IDLE, HOLD, HOLD2} state_e;

   localparam logic [2:0] SRC_I  = 3'b000;
   localparam logic [2:0] SRC_S  = 3'b001;
   localparam logic [2:0] SRC_B  = 3'b010;
   localparam logic [2:0] SRC_J  = 3'b011;
   localparam logic [2:0] SRC_U  = 3'b100;
   localparam logic [2:0] SRC_LI = 3'b101;

   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   state_e      state_q, state_d;
   logic [31:0] insn_q, insn_d;
   logic        err_q, err_d;
   logic [31:0] pend_q, pend_d;

   logic [31:0] enc_word, enc_second;
   logic        enc_err, enc_two;
   logic        fits12, fits13, fits21;
   logic [4:0]  rd;
   logic [19:0] li_hi;
   logic        accept;

   // Range checks: the bits above the field's sign bit must all equal it.
   assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
   assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
   assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});
   assign rd     = in_base[11:7];
   // ADDI sign-extends its 12 bits, so a negative low half borrows one from the upper 20.
   assign li_hi  = in_imm[31:12] + {19'd0, in_imm[11]};

   always_comb begin
      enc_word   = in_base;
      enc_err    = 1'b1;
      enc_two    = 1'b0;
      enc_second = '0;
      case (in_imm_src)
         SRC_I: begin
            enc_word = {in_imm[11:0], in_base[19:0]};
            enc_err  = !fits12;
         end
         SRC_S: begin
            enc_word = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
            enc_err  = !fits12;
         end
         SRC_B: begin
            enc_word = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1], in_imm[11], in_base[6:0]};
            enc_err  = !fits13 | in_imm[0];
         end
         SRC_J: begin
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_base[11:0]};
            enc_err  = !fits21 | in_imm[0];
         end
         SRC_U: begin
            enc_word = {in_imm[31:12], in_base[11:0]};
            enc_err  = (in_imm[11:0] != 12'd0);
         end
         SRC_LI: begin
            enc_err = 1'b0;
            if (fits12) begin
               enc_word = {in_imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
            end else if (in_imm[11:0] == 12'd0) begin
               enc_word = {in_imm[31:12], rd, OP_LUI};
            end else begin
               enc_word   = {li_hi, rd, OP_LUI};
               enc_second = {in_imm[11:0], rd, 3'b000, rd, OP_IMM};
               enc_two    = 1'b1;
            end
         end
         default: begin
            enc_word = in_base;
            enc_err  = 1'b1;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q != IDLE);
   assign out_insn  = insn_q;
   assign out_err   = err_q;

   always_comb begin
      state_d = state_q;
      insn_d  = insn_q;
      err_d   = err_q;
      pend_d  = pend_q;
      case (state_q)
         HOLD:    if (out_ready) state_d = IDLE;
         HOLD2: begin
            if (out_ready) begin
               insn_d  = pend_q;
               err_d   = 1'b0;
               state_d = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
      // accept is only possible when the register is empty or draining this cycle
      if (accept) begin
         insn_d  = enc_word;
         err_d   = enc_err;
         pend_d  = enc_second;
         state_d = enc_two ? HOLD2 : HOLD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         insn_q  <= '0;
         err_q   <= 1'b0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         insn_q  <= insn_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_imm_insn_encoder.sv
// Directed bench for imm_insn_encoder: expected words queued at drive time, popped on output handshake.
module tb_imm_insn_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_imm_src;
   logic [31:0] in_base;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_insn;
   logic        out_err;

   int total = 0;
   int bad   = 0;
   logic acc;
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   imm_insn_encoder dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm_src(in_imm_src),
      .in_base(in_base), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_err(out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sample at negedge (handshakes happen at the next posedge), then advance to posedge+1.
   task automatic step();
      logic [32:0] e;
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", out_insn, 32'hxxxxxxxx);
         end else begin
            e = sb.pop_front();
            chk("sb_insn", out_insn, e[32:1]);
            chk("sb_err", {31'd0, out_err}, {31'd0, e[0]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm);
      in_valid   = 1'b1;
      in_imm_src = src;
      in_base    = base;
      in_imm     = imm;
   endtask

   task automatic wait_acc();
      int n = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin
         step();
         n++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] exp, input logic exp_err);
      drive(src, base, imm);
      sb.push_back({exp, exp_err});
      wait_acc();
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         step();
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
      step();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_imm_src = 3'd0; in_base = '0; in_imm = '0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_insn", out_insn, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // I-type latency
      drive(3'b000, 32'h00000093, 32'd5);
      sb.push_back({32'h00500093, 1'b0});
      #1;
      chk("lat_pre_valid", {31'd0, out_valid}, 32'd0);
      wait_acc();
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_insn", out_insn, 32'h00500093);
      drain();

      send(3'b000, 32'hFFF00093, 32'd5,          32'h00500093, 1'b0); // template imm cleared
      send(3'b010, 32'h00000063, 32'hFFFFFFFC,   32'hFE000EE3, 1'b0);
      send(3'b010, 32'h00000063, 32'd3,          32'h00000163, 1'b1);
      send(3'b000, 32'h00000093, 32'd2048,       32'h80000093, 1'b1);
      send(3'b000, 32'h00000093, 32'hFFFFF800,   32'h80000093, 1'b0);
      send(3'b001, 32'h00002023, 32'hFFFFFFFF,   32'hFE002FA3, 1'b0);
      send(3'b011, 32'h0000006F, 32'd2048,       32'h0010006F, 1'b0);
      send(3'b011, 32'h0000006F, 32'h00100000,   32'h8000006F, 1'b1);
      send(3'b100, 32'h00000537, 32'h12345000,   32'h12345537, 1'b0);
      send(3'b100, 32'h00000537, 32'h12345001,   32'h12345537, 1'b1);
      send(3'b110, 32'hDEADBEEF, 32'd0,          32'hDEADBEEF, 1'b1);
      send(3'b101, 32'h00000280, 32'hFFFFFFFF,   32'hFFF00293, 1'b0);
      send(3'b101, 32'h00000280, 32'h12345000,   32'h123452B7, 1'b0);
      drain();

      // LI pair, consecutive words
      drive(3'b101, 32'h00000280, 32'h12345FFF);
      sb.push_back({32'h123462B7, 1'b0});
      sb.push_back({32'hFFF28293, 1'b0});
      wait_acc();
      chk("li_w1", out_insn, 32'h123462B7);
      chk("li_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("li_w2_valid", {31'd0, out_valid}, 32'd1);
      chk("li_w2", out_insn, 32'hFFF28293);
      drain();

      // backpressure then back-to-back accept
      out_ready = 1'b0;
      send(3'b000, 32'h00000093, 32'd7, 32'h00700093, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_insn", out_insn, 32'h00700093);
         chk("bp_err", {31'd0, out_err}, 32'd0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      drive(3'b000, 32'h00000093, 32'd9);
      sb.push_back({32'h00900093, 1'b0});
      #1;
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      wait_acc();
      chk("b2b_insn", out_insn, 32'h00900093);
      drain();

      // reset mid HOLD2
      out_ready = 1'b0;
      drive(3'b101, 32'h00000280, 32'h12345FFF);
      wait_acc();
      chk("rst2_w1", out_insn, 32'h123462B7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst2_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_insn", out_insn, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst2_no_w2", {31'd0, out_valid}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
